// File: rtl/cflog_loop_writer_pkg.sv
// Shared types for the CFLog loop writer: loop marker, write FSM encoding, pending-entry layout.
package acfa_cflog_pkg;

    localparam logic [15:0] LOOP_TAG = 16'hFFFF;

    localparam int unsigned WC_BR   = 2;
    localparam int unsigned WC_LOOP = 3;
    localparam int unsigned WC_MAX  = 5;

    typedef enum logic [2:0] {
        IDLE,
        W_TAG,
        W_CHI,
        W_CLO,
        W_SRC,
        W_DST
    } wr_state_t;

    // Field order matches the order the words leave for the log.
    typedef struct packed {
        logic        has_loop;
        logic [31:0] ctr;
        logic        has_br;
        logic [15:0] src;
        logic [15:0] dest;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [2:0] entry_words(input entry_t e);
        logic [2:0] n;
        n = 3'd0;
        if (e.has_loop) n = n + 3'(WC_LOOP);
        if (e.has_br)   n = n + 3'(WC_BR);
        return n;
    endfunction

endpackage

// File: rtl/cflog_loop_writer_if.sv
// Branch/loop event inputs and CFLog write-port outputs of the loop writer.
interface cflog_loop_writer_if #(
    parameter int unsigned LOG_AW = 8
);
    logic              branch_detect;
    logic [15:0]       branch_src;
    logic [15:0]       branch_dest;
    logic              loop_detect;
    logic [31:0]       loop_ctr;
    logic              flush;

    logic              log_wr_en;
    logic [LOG_AW-1:0] log_addr;
    logic [15:0]       log_wdata;
    logic [LOG_AW-1:0] log_ptr;
    logic              log_full;
    logic              overflow;
    logic              flush_done;

    modport master (
        output branch_detect, branch_src, branch_dest, loop_detect, loop_ctr, flush,
        input  log_wr_en, log_addr, log_wdata, log_ptr, log_full, overflow, flush_done
    );

    modport slave (
        input  branch_detect, branch_src, branch_dest, loop_detect, loop_ctr, flush,
        output log_wr_en, log_addr, log_wdata, log_ptr, log_full, overflow, flush_done
    );
endinterface

// File: rtl/cflog_loop_writer_entry_fifo.sv
// Show-ahead synchronous FIFO of pending log entries; write visible on rd_dat the cycle after push.
// No backpressure: push while full and pop while empty are ignored, callers watch full/empty.
module cflog_entry_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cflog_loop_writer.sv
// Compresses branch/loop events into CFLog words; first word written 2 cycles after the event, then 1 word/cycle.
// No backpressure from the log port; FIFO-full or log-space shortfall drops the entry and sets overflow.
module cflog_loop_writer #(
    parameter int unsigned LOG_DEPTH  = 256,
    parameter int unsigned LOG_AW     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] LOOP_TAG   = acfa_cflog_pkg::LOOP_TAG
) (
    input  logic              clk,
    input  logic              reset,
    cflog_loop_writer_if.slave bus
);
    import acfa_cflog_pkg::*;

    // One extra pointer bit so a completely full log reads as zero free words instead of wrapping.
    localparam int unsigned     PW      = LOG_AW + 1;
    localparam logic [PW-1:0]   DEPTH_W = PW'(LOG_DEPTH);
    localparam logic [PW-1:0]   MAX_W   = PW'(WC_MAX);

    wr_state_t        state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    free_words;
    logic             full_q;
    logic             ovf_q, ovf_d;
    logic             done_q;
    logic             loop_open_q, loop_open_d;
    logic             pend_q, pend_d;

    entry_t           enq_ent;
    entry_t           head;
    logic [ENTRY_W-1:0] head_raw;
    logic             enq;
    logic             drop_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             load;
    logic             discard;
    logic             drain_met;
    logic             wr_en;
    logic [15:0]      wdata;

    logic [31:0]      cur_ctr_q;
    logic             cur_has_br_q;
    logic [15:0]      cur_src_q;
    logic [15:0]      cur_dest_q;

    cflog_entry_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (enq),
        .wr_dat (enq_ent),
        .rd_en  (pop),
        .rd_dat (head_raw),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign head = entry_t'(head_raw);

    // A branch in the same cycle as a flush is classified first, so at most one entry is enqueued.
    always_comb begin
        enq         = 1'b0;
        enq_ent     = '0;
        loop_open_d = loop_open_q;
        drop_evt    = 1'b0;
        if (bus.branch_detect) begin
            if (pend_q) begin
                drop_evt = 1'b1;
            end else if (bus.loop_detect) begin
                loop_open_d = 1'b1;
            end else begin
                enq            = 1'b1;
                enq_ent.has_br = 1'b1;
                enq_ent.src    = bus.branch_src;
                enq_ent.dest   = bus.branch_dest;
                if (loop_open_q) begin
                    enq_ent.has_loop = 1'b1;
                    enq_ent.ctr      = bus.loop_ctr;
                    loop_open_d      = 1'b0;
                end
            end
        end
        if (bus.flush && loop_open_d) begin
            enq              = 1'b1;
            enq_ent          = '0;
            enq_ent.has_loop = 1'b1;
            enq_ent.ctr      = bus.loop_ctr;
            loop_open_d      = 1'b0;
        end
    end

    assign drain_met  = pend_q && fifo_empty && (state_q == IDLE);
    assign free_words = DEPTH_W - ptr_q;

    always_comb begin
        pend_d = pend_q;
        if (drain_met) pend_d = 1'b0;
        if (bus.flush) pend_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        discard = 1'b0;
        wr_en   = 1'b0;
        wdata   = 16'h0000;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (free_words < PW'(entry_words(head))) begin
                        discard = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = head.has_loop ? W_TAG : W_SRC;
                    end
                end
            end
            W_TAG: begin
                wr_en   = 1'b1;
                wdata   = LOOP_TAG;
                state_d = W_CHI;
            end
            W_CHI: begin
                wr_en   = 1'b1;
                wdata   = cur_ctr_q[31:16];
                state_d = W_CLO;
            end
            W_CLO: begin
                wr_en   = 1'b1;
                wdata   = cur_ctr_q[15:0];
                state_d = cur_has_br_q ? W_SRC : IDLE;
            end
            W_SRC: begin
                wr_en   = 1'b1;
                wdata   = cur_src_q;
                state_d = W_DST;
            end
            W_DST: begin
                wr_en   = 1'b1;
                wdata   = cur_dest_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (drain_met)  ptr_d = '0;
        else if (wr_en) ptr_d = ptr_q + 1'b1;
    end

    // A drop in the drain cycle still leaves overflow set.
    always_comb begin
        ovf_d = ovf_q;
        if (drain_met) ovf_d = 1'b0;
        if (drop_evt || (enq && fifo_full) || discard) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            loop_open_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            full_q      <= (DEPTH_W - ptr_d) < MAX_W;
            ovf_q       <= ovf_d;
            done_q      <= drain_met;
            loop_open_q <= loop_open_d;
            pend_q      <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            cur_ctr_q    <= head.ctr;
            cur_has_br_q <= head.has_br;
            cur_src_q    <= head.src;
            cur_dest_q   <= head.dest;
        end
    end

    assign bus.log_wr_en  = wr_en;
    assign bus.log_addr   = ptr_q[LOG_AW-1:0];
    assign bus.log_wdata  = wdata;
    assign bus.log_ptr    = ptr_q[LOG_AW-1:0];
    assign bus.log_full   = full_q;
    assign bus.overflow   = ovf_q;
    assign bus.flush_done = done_q;

endmodule

// File: tb/tb_cflog_loop_writer.sv
// Bench for cflog_loop_writer: three instances (default, 8-word log, 2-deep FIFO) checked against expected-word queues.
module tb_cflog_loop_writer;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_run = 0;
    int          n_fail = 0;

    logic        bd = 1'b0;
    logic        ld = 1'b0;
    logic        fl = 1'b0;
    logic [15:0] bs = '0;
    logic [15:0] bt = '0;
    logic [31:0] lc = '0;
    int          sel = 0;

    wr_t         obs_a[$], obs_b[$], obs_c[$];
    logic [31:0] exp_a[$], exp_b[$], exp_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cflog_loop_writer_if #(.LOG_AW(8)) ifa ();
    cflog_loop_writer_if #(.LOG_AW(4)) ifb ();
    cflog_loop_writer_if #(.LOG_AW(8)) ifc ();

    assign ifa.branch_detect = bd && (sel == 0);
    assign ifa.loop_detect   = ld && (sel == 0);
    assign ifa.flush         = fl && (sel == 0);
    assign ifa.branch_src    = bs;
    assign ifa.branch_dest   = bt;
    assign ifa.loop_ctr      = lc;
    assign ifb.branch_detect = bd && (sel == 1);
    assign ifb.loop_detect   = ld && (sel == 1);
    assign ifb.flush         = fl && (sel == 1);
    assign ifb.branch_src    = bs;
    assign ifb.branch_dest   = bt;
    assign ifb.loop_ctr      = lc;
    assign ifc.branch_detect = bd && (sel == 2);
    assign ifc.loop_detect   = ld && (sel == 2);
    assign ifc.flush         = fl && (sel == 2);
    assign ifc.branch_src    = bs;
    assign ifc.branch_dest   = bt;
    assign ifc.loop_ctr      = lc;

    cflog_loop_writer #(.LOG_DEPTH(256), .LOG_AW(8), .FIFO_DEPTH(4), .LOOP_TAG(16'hFFFF))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    cflog_loop_writer #(.LOG_DEPTH(8), .LOG_AW(4), .FIFO_DEPTH(4), .LOOP_TAG(16'hFFFF))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    cflog_loop_writer #(.LOG_DEPTH(256), .LOG_AW(8), .FIFO_DEPTH(2), .LOOP_TAG(16'hFFFF))
        dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    always @(negedge clk) begin
        if (ifa.log_wr_en === 1'b1) obs_a.push_back('{cyc, 16'(ifa.log_addr), ifa.log_wdata});
        if (ifb.log_wr_en === 1'b1) obs_b.push_back('{cyc, 16'(ifb.log_addr), ifb.log_wdata});
        if (ifc.log_wr_en === 1'b1) obs_c.push_back('{cyc, 16'(ifc.log_addr), ifc.log_wdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input int s, input logic [15:0] src, input logic [15:0] dst,
                      input logic l, input logic [31:0] c);
        sel = s; bd = 1'b1; bs = src; bt = dst; ld = l; lc = c;
        step();
        bd = 1'b0; ld = 1'b0;
    endtask

    task automatic test_reset();
        n_run++;
        if ({ifa.log_wr_en, ifa.log_addr, ifa.log_wdata, ifa.log_ptr, ifa.log_full, ifa.overflow, ifa.flush_done} !== '0) begin
            n_fail++; $display("FAIL reset_a outputs got %b want all zero",
                {ifa.log_wr_en, ifa.log_addr, ifa.log_wdata, ifa.log_ptr, ifa.log_full, ifa.overflow, ifa.flush_done});
        end
        n_run++;
        if ({ifb.log_wr_en, ifb.log_ptr, ifb.log_full, ifb.overflow, ifb.flush_done} !== '0) begin
            n_fail++; $display("FAIL reset_b outputs got %b want all zero",
                {ifb.log_wr_en, ifb.log_ptr, ifb.log_full, ifb.overflow, ifb.flush_done});
        end
        n_run++;
        if ({ifc.log_wr_en, ifc.log_ptr, ifc.log_full, ifc.overflow, ifc.flush_done} !== '0) begin
            n_fail++; $display("FAIL reset_c outputs got %b want all zero",
                {ifc.log_wr_en, ifc.log_ptr, ifc.log_full, ifc.overflow, ifc.flush_done});
        end
    endtask

    task automatic test_two_branches();
        int t;
        wr_t o;
        logic [31:0] e;
        t = cyc;
        exp_a.push_back({16'd0, 16'hC010}); exp_a.push_back({16'd1, 16'hC100});
        br(0, 16'hC010, 16'hC100, 1'b0, 32'd0);
        exp_a.push_back({16'd2, 16'hC120}); exp_a.push_back({16'd3, 16'hC200});
        br(0, 16'hC120, 16'hC200, 1'b0, 32'd0);
        repeat (20) step();
        n_run++;
        if (obs_a.size() == 0 || obs_a[0].cyc !== t + 2) begin
            n_fail++; $display("FAIL two_br_first_write cycle got %0d want %0d", (obs_a.size() > 0) ? obs_a[0].cyc : -1, t + 2);
        end
        n_run++;
        if (obs_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL two_br_count got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL two_br_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_a.delete(); obs_a.delete();
        n_run++;
        if (ifa.log_ptr !== 8'd4 || ifa.log_full !== 1'b0) begin
            n_fail++; $display("FAIL two_br_ptr got ptr=%0d full=%b want ptr=4 full=0", ifa.log_ptr, ifa.log_full);
        end
    endtask

    task automatic test_loop();
        wr_t o;
        logic [31:0] e;
        logic [15:0] words[7];
        words = '{16'hC030, 16'hC020, 16'hFFFF, 16'h0000, 16'h0005, 16'hC034, 16'hC400};
        for (int i = 0; i < 7; i++) exp_a.push_back({16'(4 + i), words[i]});
        br(0, 16'hC030, 16'hC020, 1'b0, 32'd1);
        for (int k = 2; k <= 5; k++) br(0, 16'hC030, 16'hC020, 1'b1, 32'(k));
        br(0, 16'hC034, 16'hC400, 1'b0, 32'd5);
        repeat (20) step();
        n_run++;
        if (obs_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL loop_count got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL loop_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_a.delete(); obs_a.delete();
        n_run++;
        if (ifa.log_ptr !== 8'd11 || ifa.overflow !== 1'b0) begin
            n_fail++; $display("FAIL loop_ptr got ptr=%0d ovf=%b want ptr=11 ovf=0", ifa.log_ptr, ifa.overflow);
        end
    endtask

    task automatic test_flush();
        wr_t o;
        logic [31:0] e;
        bit seen;
        br(0, 16'hC050, 16'hC060, 1'b1, 32'h0001_2344);
        exp_a.push_back({16'd11, 16'hFFFF}); exp_a.push_back({16'd12, 16'h0001}); exp_a.push_back({16'd13, 16'h2345});
        sel = 0; fl = 1'b1; lc = 32'h0001_2345;
        step();
        fl = 1'b0;
        // Arrives while the flush is pending, so it must be dropped.
        br(0, 16'hC070, 16'hC080, 1'b0, 32'd0);
        n_run++;
        if (ifa.overflow !== 1'b1) begin
            n_fail++; $display("FAIL flush_drop_ovf got %b want 1", ifa.overflow);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ifa.flush_done === 1'b1) seen = 1'b1;
            else step();
        end
        n_run++;
        if (!seen) begin
            n_fail++; $display("FAIL flush_done_timeout got 0 want a pulse within 20 cycles");
        end else begin
            n_run++;
            if (ifa.log_ptr !== 8'd0 || ifa.overflow !== 1'b0) begin
                n_fail++; $display("FAIL flush_done_state got ptr=%0d ovf=%b want ptr=0 ovf=0", ifa.log_ptr, ifa.overflow);
            end
            step();
            n_run++;
            if (ifa.flush_done !== 1'b0) begin
                n_fail++; $display("FAIL flush_done_pulse got %b want 0 one cycle later", ifa.flush_done);
            end
        end
        repeat (5) step();
        n_run++;
        if (obs_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL flush_count got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL flush_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

    task automatic test_log_full();
        wr_t o;
        logic [31:0] e;
        exp_b.push_back({16'd0, 16'hA000}); exp_b.push_back({16'd1, 16'hA001});
        exp_b.push_back({16'd2, 16'hA010}); exp_b.push_back({16'd3, 16'hA011});
        br(1, 16'hA000, 16'hA001, 1'b0, 32'd0);
        br(1, 16'hA010, 16'hA011, 1'b0, 32'd0);
        // Third record is a 5-word loop record; only 4 words remain in the 8-word log.
        br(1, 16'hA020, 16'hA021, 1'b1, 32'd7);
        br(1, 16'hA030, 16'hA031, 1'b0, 32'd7);
        repeat (20) step();
        n_run++;
        if (obs_b.size() !== exp_b.size()) begin
            n_fail++; $display("FAIL full_count got %0d want %0d", obs_b.size(), exp_b.size());
        end
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL full_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_b.delete(); obs_b.delete();
        n_run++;
        if (ifb.log_ptr !== 4'd4 || ifb.log_full !== 1'b1 || ifb.overflow !== 1'b1) begin
            n_fail++; $display("FAIL full_state got ptr=%0d full=%b ovf=%b want ptr=4 full=1 ovf=1",
                ifb.log_ptr, ifb.log_full, ifb.overflow);
        end
    endtask

    task automatic test_fifo_overflow();
        wr_t o;
        logic [31:0] e;
        // b1 is popped the cycle after it lands; b2 and b3 then fill the 2-deep FIFO and b4, b5 are dropped.
        for (int i = 0; i < 3; i++) begin
            exp_c.push_back({16'(2 * i), 16'hB000 + 16'(i * 16)});
            exp_c.push_back({16'(2 * i + 1), 16'hB001 + 16'(i * 16)});
        end
        for (int i = 0; i < 5; i++) br(2, 16'hB000 + 16'(i * 16), 16'hB001 + 16'(i * 16), 1'b0, 32'd0);
        repeat (20) step();
        n_run++;
        if (obs_c.size() !== exp_c.size()) begin
            n_fail++; $display("FAIL fifo_ovf_count got %0d want %0d", obs_c.size(), exp_c.size());
        end
        while (exp_c.size() > 0 && obs_c.size() > 0) begin
            e = exp_c.pop_front(); o = obs_c.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL fifo_ovf_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_c.delete(); obs_c.delete();
        n_run++;
        if (ifc.overflow !== 1'b1 || ifc.log_ptr !== 8'd6) begin
            n_fail++; $display("FAIL fifo_ovf_state got ovf=%b ptr=%0d want ovf=1 ptr=6", ifc.overflow, ifc.log_ptr);
        end
    endtask

    task automatic test_reset_mid_record();
        wr_t o;
        logic [31:0] e;
        exp_a.push_back({16'd0, 16'hFFFF}); exp_a.push_back({16'd1, 16'hABCD});
        br(0, 16'hD000, 16'hD001, 1'b1, 32'hABCD_0001);
        br(0, 16'hD010, 16'hD011, 1'b0, 32'hABCD_0001);
        step();
        step();
        @(negedge clk);
        n_run++;
        if (ifa.log_wr_en !== 1'b1 || ifa.log_wdata !== 16'hABCD) begin
            n_fail++; $display("FAIL mid_chi_word got en=%b data=%h want en=1 data=abcd", ifa.log_wr_en, ifa.log_wdata);
        end
        reset = 1'b1;
        step();
        n_run++;
        if ({ifa.log_wr_en, ifa.log_addr, ifa.log_wdata, ifa.log_ptr, ifa.log_full, ifa.overflow, ifa.flush_done} !== '0) begin
            n_fail++; $display("FAIL mid_reset_outputs got %b want all zero",
                {ifa.log_wr_en, ifa.log_addr, ifa.log_wdata, ifa.log_ptr, ifa.log_full, ifa.overflow, ifa.flush_done});
        end
        reset = 1'b0;
        repeat (10) step();
        exp_a.push_back({16'd0, 16'hE000}); exp_a.push_back({16'd1, 16'hE001});
        br(0, 16'hE000, 16'hE001, 1'b0, 32'd0);
        repeat (10) step();
        n_run++;
        if (obs_a.size() !== exp_a.size()) begin
            n_fail++; $display("FAIL mid_reset_count got %0d want %0d", obs_a.size(), exp_a.size());
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); n_run++;
            if ({o.addr, o.data} !== e) begin
                n_fail++; $display("FAIL mid_reset_word got %h@%0d want %h@%0d", o.data, o.addr, e[15:0], e[31:16]);
            end
        end
        exp_a.delete(); obs_a.delete();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_two_branches();
        test_loop();
        test_flush();
        test_log_full();
        test_fifo_overflow();
        test_reset_mid_record();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
